// File: rtl/nbit_pred.sv
// nbit_pred: table of 2**IDX_W saturating counters used as an N-bit branch
// direction predictor. One prediction port (one-cycle registered result) and
// one update port (resolved outcome) operate concurrently every cycle. A
// prediction and an update on the same entry in the same cycle see the
// post-update counter value. Miss and update statistics saturate.
module nbit_pred #(
    parameter int IDX_W      = 3,
    parameter int CTR_W      = 2,
    parameter int INIT_STATE = 1,
    parameter int STAT_W     = 16
) (
    input  logic              clk,
    input  logic              init,
    input  logic              pred_valid,
    input  logic [IDX_W-1:0]  pred_addr,
    output logic              pred_rdy,
    output logic              pred_taken,
    input  logic              upd_valid,
    input  logic [IDX_W-1:0]  upd_addr,
    input  logic              upd_outcome,
    output logic [STAT_W-1:0] miss_cnt,
    output logic [STAT_W-1:0] upd_cnt
);

    localparam int DEPTH = 2 ** IDX_W;

    localparam logic [CTR_W-1:0]  CTR_ZERO  = '0;
    localparam logic [CTR_W-1:0]  CTR_ONE   = CTR_W'(1);
    localparam logic [CTR_W-1:0]  CTR_MAX   = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0]  CTR_INIT  = CTR_W'(INIT_STATE);
    localparam logic [STAT_W-1:0] STAT_ZERO = '0;
    localparam logic [STAT_W-1:0] STAT_ONE  = STAT_W'(1);
    localparam logic [STAT_W-1:0] STAT_MAX  = {STAT_W{1'b1}};

    // Saturating up/down step of one predictor counter.
    function automatic logic [CTR_W-1:0] ctr_step(
        input logic [CTR_W-1:0] cur,
        input logic             up
    );
        logic [CTR_W-1:0] nxt;
        nxt = cur;
        if (up) begin
            if (cur != CTR_MAX) begin
                nxt = cur + CTR_ONE;
            end else begin
                nxt = cur;
            end
        end else begin
            if (cur != CTR_ZERO) begin
                nxt = cur - CTR_ONE;
            end else begin
                nxt = cur;
            end
        end
        return nxt;
    endfunction

    // Conditional saturating increment of a statistics counter.
    function automatic logic [STAT_W-1:0] stat_inc(
        input logic [STAT_W-1:0] cur,
        input logic              en
    );
        logic [STAT_W-1:0] nxt;
        nxt = cur;
        if (en && (cur != STAT_MAX)) begin
            nxt = cur + STAT_ONE;
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

    logic [CTR_W-1:0]  ctr_tbl_r [DEPTH];
    logic              pred_rdy_r;
    logic              pred_taken_r;
    logic [STAT_W-1:0] miss_cnt_r;
    logic [STAT_W-1:0] upd_cnt_r;

    logic [CTR_W-1:0]  upd_cur_s;
    logic [CTR_W-1:0]  upd_new_s;
    logic              upd_miss_s;
    logic              fwd_hit_s;
    logic [CTR_W-1:0]  pred_ctr_s;
    logic [STAT_W-1:0] miss_nxt_s;
    logic [STAT_W-1:0] upd_nxt_s;

    // Update-port datapath: current entry, its next value and miss detection.
    always_comb begin
        upd_cur_s  = ctr_tbl_r[upd_addr];
        upd_new_s  = ctr_step(upd_cur_s, upd_outcome);
        upd_miss_s = upd_outcome ^ upd_cur_s[CTR_W-1];
    end

    // Prediction read with write-first forwarding from a same-entry update.
    always_comb begin
        fwd_hit_s  = upd_valid && (upd_addr == pred_addr);
        pred_ctr_s = CTR_ZERO;
        if (fwd_hit_s) begin
            pred_ctr_s = upd_new_s;
        end else begin
            pred_ctr_s = ctr_tbl_r[pred_addr];
        end
    end

    // Next values of the saturating statistics counters.
    always_comb begin
        miss_nxt_s = STAT_ZERO;
        upd_nxt_s  = STAT_ZERO;
        if (upd_valid) begin
            miss_nxt_s = stat_inc(miss_cnt_r, upd_miss_s);
            upd_nxt_s  = stat_inc(upd_cnt_r, 1'b1);
        end else begin
            miss_nxt_s = miss_cnt_r;
            upd_nxt_s  = upd_cnt_r;
        end
    end

    // Counter table: reload on reset, otherwise only the updated entry changes.
    always_ff @(posedge clk) begin
        if (!init) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_tbl_r[i] <= CTR_INIT;
            end
        end else if (upd_valid) begin
            ctr_tbl_r[upd_addr] <= upd_new_s;
        end else begin
            ctr_tbl_r[upd_addr] <= ctr_tbl_r[upd_addr];
        end
    end

    // Registered prediction result; direction holds while no request is served.
    always_ff @(posedge clk) begin
        if (!init) begin
            pred_rdy_r   <= 1'b0;
            pred_taken_r <= 1'b0;
        end else if (pred_valid) begin
            pred_rdy_r   <= 1'b1;
            pred_taken_r <= pred_ctr_s[CTR_W-1];
        end else begin
            pred_rdy_r   <= 1'b0;
            pred_taken_r <= pred_taken_r;
        end
    end

    // Registered miss and update statistics.
    always_ff @(posedge clk) begin
        if (!init) begin
            miss_cnt_r <= STAT_ZERO;
            upd_cnt_r  <= STAT_ZERO;
        end else begin
            miss_cnt_r <= miss_nxt_s;
            upd_cnt_r  <= upd_nxt_s;
        end
    end

    assign pred_rdy   = pred_rdy_r;
    assign pred_taken = pred_taken_r;
    assign miss_cnt   = miss_cnt_r;
    assign upd_cnt    = upd_cnt_r;

endmodule

// File: tb/tb_nbit_pred.sv
// Self-checking bench for nbit_pred: directed vector table, randomized traffic
// against a behavioural model, a reset-collision sequence and a narrow
// statistics-counter instance for saturation.
module tb_nbit_pred;

    logic        clk;
    logic        init;
    logic        pred_valid;
    logic [2:0]  pred_addr;
    logic        pred_rdy;
    logic        pred_taken;
    logic        upd_valid;
    logic [2:0]  upd_addr;
    logic        upd_outcome;
    logic [15:0] miss_cnt;
    logic [15:0] upd_cnt;

    logic        s_init;
    logic        s_pred_valid;
    logic [2:0]  s_pred_addr;
    logic        s_pred_rdy;
    logic        s_pred_taken;
    logic        s_upd_valid;
    logic [2:0]  s_upd_addr;
    logic        s_upd_outcome;
    logic [1:0]  s_miss_cnt;
    logic [1:0]  s_upd_cnt;

    int errs;
    int checks;

    nbit_pred #(.IDX_W(3), .CTR_W(2), .INIT_STATE(1), .STAT_W(16)) dut (
        .clk(clk), .init(init), .pred_valid(pred_valid), .pred_addr(pred_addr),
        .pred_rdy(pred_rdy), .pred_taken(pred_taken), .upd_valid(upd_valid),
        .upd_addr(upd_addr), .upd_outcome(upd_outcome), .miss_cnt(miss_cnt),
        .upd_cnt(upd_cnt)
    );

    nbit_pred #(.IDX_W(3), .CTR_W(2), .INIT_STATE(1), .STAT_W(2)) dut_s (
        .clk(clk), .init(s_init), .pred_valid(s_pred_valid), .pred_addr(s_pred_addr),
        .pred_rdy(s_pred_rdy), .pred_taken(s_pred_taken), .upd_valid(s_upd_valid),
        .upd_addr(s_upd_addr), .upd_outcome(s_upd_outcome), .miss_cnt(s_miss_cnt),
        .upd_cnt(s_upd_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: counters as integers, direction = upper half of range.
    int m_tbl [8];
    int m_miss;
    int m_upd;
    bit m_rdy;
    bit m_taken;

    task automatic model_step(input bit ini, input bit pv, input int pa,
                              input bit uv, input int ua, input bit uo);
        int  old;
        bit  dir;
        if (!ini) begin
            for (int i = 0; i < 8; i++) m_tbl[i] = 1;
            m_miss = 0; m_upd = 0; m_rdy = 0; m_taken = 0;
        end else begin
            if (uv) begin
                old = m_tbl[ua];
                dir = (old >= 2);
                if (uo != dir) m_miss = (m_miss < 65535) ? m_miss + 1 : m_miss;
                m_upd = (m_upd < 65535) ? m_upd + 1 : m_upd;
                m_tbl[ua] = uo ? ((old < 3) ? old + 1 : 3) : ((old > 0) ? old - 1 : 0);
            end
            if (pv) begin
                m_rdy   = 1;
                m_taken = (m_tbl[pa] >= 2);
            end else begin
                m_rdy = 0;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_main(input string tag, input bit er, input bit et,
                            input int em, input int eu);
        chk({tag, ".pred_rdy"},   int'(pred_rdy),   int'(er));
        chk({tag, ".pred_taken"}, int'(pred_taken), int'(et));
        chk({tag, ".miss_cnt"},   int'(miss_cnt),   em);
        chk({tag, ".upd_cnt"},    int'(upd_cnt),    eu);
    endtask

    // Drive one cycle on the main instance, advance the model, sample after edge.
    task automatic step(input bit ini, input bit pv, input int pa,
                        input bit uv, input int ua, input bit uo);
        init        = ini;
        pred_valid  = pv;
        pred_addr   = 3'(pa);
        upd_valid   = uv;
        upd_addr    = 3'(ua);
        upd_outcome = uo;
        @(posedge clk);
        model_step(ini, pv, pa, uv, ua, uo);
        #1;
    endtask

    typedef struct {
        bit ini; bit pv; int pa; bit uv; int ua; bit uo;
        bit e_rdy; bit e_tkn; int e_miss; int e_upd;
    } vec_t;

    function automatic vec_t mk(bit ini, bit pv, int pa, bit uv, int ua, bit uo,
                                bit er, bit et, int em, int eu);
        vec_t v;
        v.ini = ini; v.pv = pv; v.pa = pa; v.uv = uv; v.ua = ua; v.uo = uo;
        v.e_rdy = er; v.e_tkn = et; v.e_miss = em; v.e_upd = eu;
        return v;
    endfunction

    vec_t vecs [15];

    initial begin
        errs = 0;
        checks = 0;
        init = 1'b0; pred_valid = 1'b0; pred_addr = 3'd0;
        upd_valid = 1'b0; upd_addr = 3'd0; upd_outcome = 1'b0;
        s_init = 1'b0; s_pred_valid = 1'b0; s_pred_addr = 3'd0;
        s_upd_valid = 1'b0; s_upd_addr = 3'd0; s_upd_outcome = 1'b0;

        //             ini pv pa uv ua uo   rdy tkn miss upd
        vecs[0]  = mk(0, 0, 0, 0, 0, 0,   0,  0,  0,  0); // reset
        vecs[1]  = mk(1, 1, 1, 0, 0, 0,   1,  0,  0,  0); // predict addr1 from init
        vecs[2]  = mk(1, 0, 0, 1, 1, 1,   0,  0,  1,  1); // 1->2, miss
        vecs[3]  = mk(1, 0, 0, 1, 1, 1,   0,  0,  1,  2); // 2->3, hit
        vecs[4]  = mk(1, 1, 1, 0, 0, 0,   1,  1,  1,  2); // predict taken
        vecs[5]  = mk(1, 0, 0, 1, 1, 1,   0,  1,  1,  3); // saturated
        vecs[6]  = mk(1, 0, 0, 1, 1, 1,   0,  1,  1,  4);
        vecs[7]  = mk(1, 0, 0, 1, 1, 1,   0,  1,  1,  5);
        vecs[8]  = mk(1, 0, 0, 1, 1, 0,   0,  1,  2,  6); // 3->2, miss
        vecs[9]  = mk(1, 1, 1, 0, 0, 0,   1,  1,  2,  6); // still taken
        vecs[10] = mk(1, 1, 2, 0, 0, 0,   1,  0,  2,  6); // addr2 untouched
        vecs[11] = mk(1, 1, 5, 1, 5, 1,   1,  1,  3,  7); // forwarded 1->2
        vecs[12] = mk(1, 1, 5, 0, 0, 0,   1,  1,  3,  7);
        vecs[13] = mk(1, 1, 3, 1, 6, 0,   1,  0,  3,  8); // different addrs
        vecs[14] = mk(1, 0, 0, 0, 0, 0,   0,  0,  3,  8); // taken holds

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].ini, vecs[i].pv, vecs[i].pa, vecs[i].uv, vecs[i].ua, vecs[i].uo);
            chk_main($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_tkn,
                     vecs[i].e_miss, vecs[i].e_upd);
        end

        // Randomized traffic against the model, with occasional resets.
        for (int i = 0; i < 400; i++) begin
            bit ini, pv, uv, uo;
            int pa, ua;
            ini = ($urandom_range(0, 59) != 0);
            pv  = $urandom_range(0, 1);
            uv  = ($urandom_range(0, 3) != 0);
            uo  = $urandom_range(0, 1);
            ua  = $urandom_range(0, 7);
            pa  = ($urandom_range(0, 2) == 0) ? ua : int'($urandom_range(0, 7));
            step(ini, pv, pa, uv, ua, uo);
            chk_main("rand", m_rdy, m_taken, m_miss, m_upd);
        end

        // Train, predict, then reset coincident with request and update.
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0, 1, i, 1);
            step(1, 0, 0, 1, i, 1);
        end
        step(1, 1, 4, 0, 0, 0);
        chk_main("trained", 1'b1, 1'b1, m_miss, m_upd);
        step(0, 1, 4, 1, 4, 1);
        chk_main("rst_collide", 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(1, 1, i, 0, 0, 0);
            chk_main($sformatf("post_rst%0d", i), 1'b1, 1'b0, 0, 0);
        end

        // Narrow statistics: five alternating mispredictions on one entry.
        init = 1'b1; pred_valid = 1'b0; upd_valid = 1'b0;
        s_init = 1'b0;
        @(posedge clk); #1;
        chk("sat.reset_miss", int'(s_miss_cnt), 0);
        chk("sat.reset_upd",  int'(s_upd_cnt),  0);
        s_init = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            s_upd_valid   = 1'b1;
            s_upd_addr    = 3'd0;
            s_upd_outcome = (k % 2 == 1);
            @(posedge clk); #1;
            chk($sformatf("sat%0d.miss", k), int'(s_miss_cnt), (k < 3) ? k : 3);
            chk($sformatf("sat%0d.upd", k),  int'(s_upd_cnt),  (k < 3) ? k : 3);
            chk($sformatf("sat%0d.rdy", k),  int'(s_pred_rdy), 0);
        end
        s_upd_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/nbit_pred.md
NBIT_PRED -- requirements
Module: nbit_pred

Interface
REQ-001 Parameter IDX_W, default 3, table index width; table depth is 2**IDX_W entries.
REQ-002 Parameter CTR_W, default 2, saturating counter width per entry; legal range 1..4 (CTR_W=1 is the legacy 1-bit predictor).
REQ-003 Parameter INIT_STATE, default 1, counter value loaded into every entry at reset; legal range 0..2**CTR_W-1.
REQ-004 Parameter STAT_W, default 16, width of the statistics counters.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 init  input  1  reset, synchronous, active-low.
REQ-007 pred_valid  input  1  prediction request this cycle.
REQ-008 pred_addr  input  IDX_W  table index for prediction.
REQ-009 pred_rdy  output  1  registered; high one cycle after an accepted request.
REQ-010 pred_taken  output  1  registered; predicted direction, valid when pred_rdy=1.
REQ-011 upd_valid  input  1  resolved-branch update this cycle.
REQ-012 upd_addr  input  IDX_W  table index to update.
REQ-013 upd_outcome  input  1  actual direction, 1 = taken.
REQ-014 miss_cnt  output  STAT_W  registered count of mispredicted updates.
REQ-015 upd_cnt  output  STAT_W  registered count of all updates.

Function
REQ-016 Table holds 2**IDX_W counters of CTR_W bits; entry predicts taken when its MSB is 1.
REQ-017 Prediction latency: pred_valid at edge N -> pred_rdy=1 and pred_taken valid after edge N+1-only, i.e. visible in cycle N+1; pred_rdy=0 in any cycle not following an accepted request.
REQ-018 pred_taken holds its last value while pred_rdy=0.
REQ-019 Update: upd_outcome=1 increments entry at upd_addr, saturating at 2**CTR_W-1; upd_outcome=0 decrements, saturating at 0.
REQ-020 Miss: an update is a miss when upd_outcome differs from the entry MSB before that update; miss_cnt increments by 1 on each miss.
REQ-021 upd_cnt increments by 1 on every upd_valid cycle.
REQ-022 Both statistics counters saturate at 2**STAT_W-1; no wrap.
REQ-023 Simultaneous pred_valid and upd_valid to the same address: pred_taken reflects the post-update counter value (write-first forwarding).
REQ-024 Simultaneous pred_valid and upd_valid to different addresses: both proceed independently, no stall.
REQ-025 Back-to-back predictions are accepted every cycle; no backpressure exists.
REQ-026 Only the entry at upd_addr changes in an update cycle; all other entries hold.

Reset
REQ-027 init=0 at a rising edge: every table entry <- INIT_STATE, pred_rdy <- 0, pred_taken <- 0, miss_cnt <- 0, upd_cnt <- 0.
REQ-028 init=0 overrides pred_valid and upd_valid in the same cycle; a request or update coincident with reset is discarded.
REQ-029 A prediction issued the cycle before reset asserts yields pred_rdy=0 after the reset edge.

Verification (IDX_W=3, CTR_W=2, INIT_STATE=1, STAT_W=16 unless stated)
REQ-030 Reset, then predict addr 3'b001 -> next cycle pred_rdy=1, pred_taken=0; miss_cnt=0, upd_cnt=0.
REQ-031 Update addr 1 taken twice, then predict addr 1 -> entry 1->2->3, pred_taken=1; miss_cnt=1 (first update only), upd_cnt=2.
REQ-032 Update addr 1 taken 3 more times (saturated at 3), then not-taken once -> entry 2, pred_taken=1 on predict; addr 2 still predicts 0.
REQ-033 Same cycle: pred_valid and upd_valid on addr 5 with upd_outcome=1 from INIT_STATE=1 -> pred_taken=1 next cycle (forwarded value 2).
REQ-034 STAT_W=2: issue 5 mispredicting updates -> miss_cnt holds at 3, upd_cnt holds at 3.
REQ-035 After training entries, assert init=0 for one cycle coincident with pred_valid -> pred_rdy=0, all counters 0, all addresses predict 0 afterwards.
